vote_tally_ctrl: RTL and testbench

//   Parametrised successor of the voting-station controller: collects debounced button votes for
//   NUM_CAND candidates into saturating counters, ships each tally over the rts/rtr send handshake,

---
 rtl/vote_tally_ctrl.sv | 167 ++++++++++++++++
 tb/tb_vote_tally_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_tally_ctrl.sv
// Voting-station controller: counts debounced button edges into saturating
// tallies, ships them over rts/rtr, then waits for an ack over ctr/cts with bounded retries.
module vote_tally_ctrl #(
    parameter int                NUM_CAND  = 2,
    parameter int                CNT_W     = 4,
    parameter logic [CNT_W-1:0]  ACK_CODE  = 4'hF,
    parameter int                MAX_RETRY = 3,
    parameter logic [CNT_W-1:0]  TEST_PAT  = 4'hA
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                key,
    input  logic                test,
    input  logic [NUM_CAND-1:0] btn,
    input  logic                rtr,
    output logic                rts,
    output logic [CNT_W-1:0]    v_out,
    input  logic                ctr,
    output logic                cts,
    input  logic [CNT_W-1:0]    v_in,
    output logic                busy,
    output logic                fail
);

    localparam int               IDX_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_SEND,
        S_RECV,
        S_TEST,
        S_FAIL
    } state_t;

    state_t                         state, state_n;
    logic [NUM_CAND-1:0][CNT_W-1:0] tally, tally_n;
    logic [NUM_CAND-1:0]            last_btn;
    logic [NUM_CAND-1:0]            edges;
    logic [IDX_W-1:0]               idx, idx_n;
    logic [3:0]                     retry, retry_n;
    logic                           rts_n, cts_n, busy_n, fail_n;
    logic [CNT_W-1:0]               v_out_n;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        tally_n = tally;
        idx_n   = idx;
        retry_n = retry;
        edges   = btn & ~last_btn;

        case (state)
            S_IDLE: begin
                if (test) begin
                    state_n = S_TEST;
                end else if (start && key) begin
                    state_n = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (key) begin
                    for (int i = 0; i < NUM_CAND; i++) begin
                        if (edges[i] && (tally[i] != CNT_MAX)) begin
                            tally_n[i] = tally[i] + CNT_W'(1);
                        end
                    end
                end
                if (!start) begin
                    state_n = S_SEND;
                    idx_n   = '0;
                end
            end

            S_SEND: begin
                // rts and rtr both high is one accepted word; no idle cycle between words.
                if (rts && rtr) begin
                    if (idx == LAST_IDX) begin
                        state_n = S_RECV;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end

            S_RECV: begin
                if (cts && ctr) begin
                    if (v_in == ACK_CODE) begin
                        tally_n = '0;
                        retry_n = '0;
                        state_n = S_IDLE;
                    end else if (retry < RETRY_LIM) begin
                        retry_n = retry + 4'd1;
                        idx_n   = '0;
                        state_n = S_SEND;
                    end else begin
                        state_n = S_FAIL;
                    end
                end
            end

            S_TEST: begin
                if (rts && rtr) begin
                    state_n = S_IDLE;
                end
            end

            S_FAIL: begin
                state_n = S_FAIL;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Outputs are decoded from the upcoming state so the registered
        // copies line up with the state register.
        rts_n   = (state_n == S_SEND) || (state_n == S_TEST);
        cts_n   = (state_n == S_RECV);
        busy_n  = (state_n != S_IDLE) && (state_n != S_FAIL);
        fail_n  = (state_n == S_FAIL);
        v_out_n = '0;
        if (state_n == S_SEND) begin
            v_out_n = tally_n[idx_n];
        end else if (state_n == S_TEST) begin
            v_out_n = TEST_PAT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            // NOTE: the tally bank is a handful of flops, not a RAM, so it is
            // cleared by reset along with the rest of the state.
            tally    <= '0;
            last_btn <= '0;
            idx      <= '0;
            retry    <= '0;
            rts      <= 1'b0;
            cts      <= 1'b0;
            busy     <= 1'b0;
            fail     <= 1'b0;
            v_out    <= '0;
        end else begin
            state    <= state_n;
            tally    <= tally_n;
            last_btn <= btn;
            idx      <= idx_n;
            retry    <= retry_n;
            rts      <= rts_n;
            cts      <= cts_n;
            busy     <= busy_n;
            fail     <= fail_n;
            v_out    <= v_out_n;
        end
    end

endmodule

// File: tb/tb_vote_tally_ctrl.sv
// Self-checking bench for vote_tally_ctrl: table-driven sessions, directed
// corner cases and randomized sessions checked against a vote-counting model.
module tb_vote_tally_ctrl;

    localparam int NC = 2;
    localparam int CW = 4;
    localparam int SAT = 15;

    logic          clock = 1'b0;
    logic          reset;
    logic          start, key, test, rtr, ctr;
    logic [NC-1:0] btn;
    logic [CW-1:0] v_in;
    logic          rts, cts, busy, fail;
    logic [CW-1:0] v_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int p0;
        int p1;
        bit key_on;
        int e0;
        int e1;
    } vec_t;

    vec_t vecs[6];

    vote_tally_ctrl #(
        .NUM_CAND (NC),
        .CNT_W    (CW),
        .ACK_CODE (4'hF),
        .MAX_RETRY(3),
        .TEST_PAT (4'hA)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .key  (key),
        .test (test),
        .btn  (btn),
        .rtr  (rtr),
        .rts  (rts),
        .v_out(v_out),
        .ctr  (ctr),
        .cts  (cts),
        .v_in (v_in),
        .busy (busy),
        .fail (fail)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_rts"},  32'(rts),  0);
        check({name, "_cts"},  32'(cts),  0);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_fail"}, 32'(fail), 0);
    endtask

    task automatic open_session();
        btn = '0; start = 1'b1; key = 1'b1;
        tick();
        check("open_busy", 32'(busy), 1);
        check("open_rts",  32'(rts),  0);
    endtask

    task automatic pulses(input int p0, input int p1);
        int n;
        n = (p0 > p1) ? p0 : p1;
        for (int i = 0; i < n; i++) begin
            btn[0] = (i < p0);
            btn[1] = (i < p1);
            tick();
            btn = '0;
            tick();
        end
    endtask

    task automatic close_session();
        btn = '0; key = 1'b1; start = 1'b0;
        tick();
    endtask

    // Expects rts high with the words exp0, exp1 in order, then the receive phase.
    task automatic send_words(input int exp0, input int exp1, input bit stall);
        int k;
        int cyc;
        int w[2];
        w[0] = exp0; w[1] = exp1;
        k = 0; cyc = 0;
        while (k < 2 && cyc < 40) begin
            check("send_rts",  32'(rts),   1);
            check("send_vout", 32'(v_out), w[k]);
            rtr = stall ? ((cyc % 7 == 6) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
            tick();
            if (rtr) k++;
            cyc++;
        end
        rtr = 1'b0;
        if (k < 2) check("send_timeout", k, 2);
        check("recv_cts", 32'(cts), 1);
        check("recv_rts", 32'(rts), 0);
    endtask

    task automatic ack(input logic [CW-1:0] code);
        ctr = 1'b1; v_in = code;
        tick();
        ctr = 1'b0; v_in = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int m[NC];
    logic [NC-1:0] prev;
    int nbad;

    initial begin
        vecs[0] = '{p0: 3,  p1: 1,  key_on: 1'b1, e0: 3,  e1: 1};
        vecs[1] = '{p0: 20, p1: 0,  key_on: 1'b1, e0: 15, e1: 0};
        vecs[2] = '{p0: 4,  p1: 5,  key_on: 1'b0, e0: 0,  e1: 0};
        vecs[3] = '{p0: 15, p1: 16, key_on: 1'b1, e0: 15, e1: 15};
        vecs[4] = '{p0: 0,  p1: 0,  key_on: 1'b1, e0: 0,  e1: 0};
        vecs[5] = '{p0: 7,  p1: 2,  key_on: 1'b1, e0: 7,  e1: 2};

        reset = 1'b1; start = 0; key = 0; test = 0; rtr = 0; ctr = 0;
        btn = '0; v_in = '0;
        tick(); tick();
        check_idle("reset");
        check("reset_vout", 32'(v_out), 0);
        reset = 1'b0;
        tick();
        check_idle("post_reset");

        for (int v = 0; v < 6; v++) begin
            open_session();
            key = vecs[v].key_on;
            pulses(vecs[v].p0, vecs[v].p1);
            close_session();
            send_words(vecs[v].e0, vecs[v].e1, 1'b0);
            ack(4'hF);
            check_idle("vec_ack");
        end

        // Three bad acks each trigger a full resend; the fourth ack is good.
        open_session();
        pulses(3, 1);
        close_session();
        send_words(3, 1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            ack(4'h5);
            check("retry_cts",  32'(cts),  0);
            check("retry_busy", 32'(busy), 1);
            send_words(3, 1, 1'b0);
        end
        ack(4'hF);
        check_idle("retry_ok");
        open_session();
        pulses(1, 0);
        close_session();
        send_words(1, 0, 1'b0);
        ack(4'hF);

        // Four bad acks exhaust the retries; FAIL ignores all inputs.
        open_session();
        pulses(2, 2);
        close_session();
        send_words(2, 2, 1'b0);
        for (int r = 0; r < 3; r++) begin
            ack(4'h5);
            send_words(2, 2, 1'b0);
        end
        ack(4'h5);
        for (int c = 0; c < 6; c++) begin
            check("fail_flag", 32'(fail), 1);
            check("fail_busy", 32'(busy), 0);
            check("fail_rts",  32'(rts),  0);
            check("fail_cts",  32'(cts),  0);
            start = c[0]; ctr = ~c[0]; test = c[1]; rtr = 1'b1; key = 1'b1;
            tick();
        end
        start = 0; ctr = 0; test = 0; rtr = 0; key = 0;
        do_reset();
        check_idle("fail_cleared");

        // Self-test has priority over start and leaves the tallies at zero.
        test = 1'b1; start = 1'b1; key = 1'b1;
        tick();
        test = 1'b0; start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("test_rts",  32'(rts),   1);
            check("test_vout", 32'(v_out), 32'hA);
            check("test_busy", 32'(busy),  1);
            tick();
        end
        rtr = 1'b1;
        tick();
        rtr = 1'b0;
        check_idle("test_done");
        open_session();
        pulses(2, 1);
        close_session();
        send_words(2, 1, 1'b0);
        ack(4'hF);

        // Reset wins over a coincident rtr in SEND.
        open_session();
        pulses(4, 2);
        close_session();
        check("rst_send_rts", 32'(rts), 1);
        rtr = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; rtr = 1'b0;
        check_idle("rst_send");
        check("rst_send_vout", 32'(v_out), 0);
        open_session();
        pulses(1, 1);
        close_session();
        send_words(1, 1, 1'b0);
        ack(4'hF);

        // Randomized sessions against a rising-edge counting model.
        for (int s = 0; s < 30; s++) begin
            m[0] = 0; m[1] = 0; prev = '0;
            open_session();
            for (int c = 0; c < int'($urandom_range(5, 40)); c++) begin
                btn = NC'($urandom);
                key = 1'($urandom_range(0, 3) != 0);
                tick();
                for (int i = 0; i < NC; i++) begin
                    if (key && btn[i] && !prev[i]) m[i] = (m[i] < SAT) ? m[i] + 1 : SAT;
                end
                prev = btn;
            end
            close_session();
            send_words(m[0], m[1], 1'b1);
            nbad = int'($urandom_range(0, 4));
            for (int r = 0; r < nbad; r++) begin
                ack(CW'($urandom_range(0, 14)));
                if (r < 3) send_words(m[0], m[1], 1'b1);
            end
            if (nbad == 4) begin
                check("rand_fail", 32'(fail), 1);
                check("rand_fail_busy", 32'(busy), 0);
                do_reset();
                check_idle("rand_reset");
            end else begin
                ack(4'hF);
                check_idle("rand_ack");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
